// File: rtl/gimli_lwc_pkg.sv
// rtl/gimli_lwc_pkg.sv - shared encodings for the Gimli LWC output arbiter
package gimli_lwc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage : gimli_lwc_pkg

// File: rtl/gimli_lwc_out_arbiter.sv
// rtl/gimli_lwc_out_arbiter.sv - packet-locked two-source arbiter feeding the LWC output buffer
module gimli_lwc_out_arbiter
    import gimli_lwc_pkg::*;
#(
    parameter int G_WIDTH = 32,
    parameter bit G_RR    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [G_WIDTH-1:0] s0_data,
    input  logic               s0_last,
    input  logic               s0_valid,
    output logic               s0_ready,
    input  logic [G_WIDTH-1:0] s1_data,
    input  logic               s1_last,
    input  logic               s1_valid,
    output logic               s1_ready,
    output logic [G_WIDTH-1:0] m_data,
    output logic               m_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic [1:0]         grant
);

    arb_state_e state_q, state_d;
    logic       prio_q, prio_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // All outputs decode from state_q, so an asynchronous reset clears them without a clock.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;
        m_valid  = 1'b0;
        busy     = 1'b0;
        grant    = GRANT_NONE;

        case (state_q)
            ST_IDLE: begin
                if (s0_valid && (!s1_valid || !prio_q)) begin
                    state_d = ST_GNT0;
                end else if (s1_valid) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                busy     = 1'b1;
                grant    = GRANT_S0;
                m_data   = s0_data;
                m_last   = s0_last;
                m_valid  = s0_valid;
                s0_ready = m_ready;
                if (s0_valid && m_ready && s0_last) begin
                    state_d = ST_IDLE;
                    prio_d  = G_RR;
                end
            end
            ST_GNT1: begin
                busy     = 1'b1;
                grant    = GRANT_S1;
                m_data   = s1_data;
                m_last   = s1_last;
                m_valid  = s1_valid;
                s1_ready = m_ready;
                if (s1_valid && m_ready && s1_last) begin
                    state_d = ST_IDLE;
                    prio_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : gimli_lwc_out_arbiter
